// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with divide-by-zero/overflow resolved at start.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [CNTW-1:0]  LAST    = CNTW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;

  logic               is_div, a_signed, b_signed, a_sgn, b_sgn, neg_start;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fin;
  logic [WIDTH-1:0]   q_fin, r_fin, final_res;

  always_comb begin
    is_div    = funct3[2];
    a_signed  = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
    b_signed  = is_div ? !funct3[0] : !funct3[1];
    a_sgn     = a_signed & rs1_data[WIDTH-1];
    b_sgn     = b_signed & rs2_data[WIDTH-1];
    // Remainder takes the dividend's sign; every other result the xor of both.
    neg_start = (is_div & funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
    a_mag     = a_sgn ? (~rs1_data + 1'b1) : rs1_data;
    b_mag     = b_sgn ? (~rs2_data + 1'b1) : rs2_data;
    div_zero  = is_div && (rs2_data == '0);
    div_ovf   = is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
    if (div_zero) begin
      special_res = funct3[1] ? rs1_data : '1;
    end else begin
      special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    step     = op_q[2] ? div_next : mul_next;
    prod_fin = neg_q ? (~step + 1'b1) : step;
    q_fin    = neg_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
    r_fin    = neg_q ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
    case (op_q)
      3'd0:          final_res = prod_fin[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod_fin[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:    final_res = q_fin;
      default:       final_res = r_fin;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3;
          neg_d = neg_start;
          cnt_d = '0;
          // Multiply walks the multiplier in the low half; divide shifts the dividend out of it.
          acc_d = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          b_d   = is_div ? b_mag : a_mag;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LAST) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = reset_n && (((state_q == S_IDLE) && start) || (state_q == S_CALC));
  assign done   = reset_n && (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus reset, overflow and back-to-back sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vq[$];

  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    #1;
    chk({nm, "_busy_req"}, {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom_range(0, 7));
    cyc = 1;
    chk({nm, "_busy_after"}, {31'b0, busy}, (lat > 1) ? 32'd1 : 32'd0);
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_busy_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({nm, "_result_hold"}, result, exp);
  endtask

  initial begin
    vq.push_back('{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33});
    vq.push_back('{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33});
    vq.push_back('{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33});
    vq.push_back('{3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33});
    vq.push_back('{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vq.push_back('{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vq.push_back('{3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33});
    vq.push_back('{3'd7, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33});
    vq.push_back('{3'd4, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1});
    vq.push_back('{3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1});
    vq.push_back('{3'd6, 32'h12345678, 32'h00000000, 32'h12345678, 1});
    vq.push_back('{3'd7, 32'h12345678, 32'h00000000, 32'h12345678, 1});
    vq.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vq.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vq.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
    vq.push_back('{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
    vq.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vq.push_back('{3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 33});
    vq.push_back('{3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 33});
    vq.push_back('{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vq.push_back('{3'd0, 32'h00000003, 32'h00000005, 32'h0000000F, 33});
    vq.push_back('{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    vq.push_back('{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
    vq.push_back('{3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33});
    vq.push_back('{3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 33});
    vq.push_back('{3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 33});
    vq.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vq.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vq.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
    vq.push_back('{3'd4, 32'h80000000, 32'h00000002, 32'hC0000000, 33});

    reset_n = 1'b0; start = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    start = 1'b0;
    reset_n = 1'b1;

    foreach (vq[i]) begin
      run_op($sformatf("vec%0d", i), vq[i].f3, vq[i].a, vq[i].b, vq[i].exp, vq[i].lat);
    end

    // Abandon a multiply mid-iteration with reset.
    @(negedge clk);
    funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("rst_calc_nodone", {31'b0, done}, 32'd0);
      chk("rst_calc_busy", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_calc_busy_low", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_calc_done", {31'b0, done}, 32'd0);
      chk("rst_calc_result", result, 32'd0);
      chk("rst_calc_busy_rst", {31'b0, busy}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      chk("rst_after_nodone", {31'b0, done}, 32'd0);
    end
    run_op("rst_then_mul", 3'd0, 32'd3, 32'd5, 32'd15, 33);

    // start held high: accepts at cycles 0, 34, 68; operands scrambled outside accept cycles.
    @(negedge clk);
    funct3 = 3'd3; start = 1'b1;
    for (int c = 0; c < 102; c++) begin
      int phase;
      phase = c % 34;
      if (phase == 0) begin
        rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF;
      end else begin
        rs1_data = $urandom; rs2_data = $urandom;
      end
      #1;
      chk("b2b_done", {31'b0, done}, (phase == 33) ? 32'd1 : 32'd0);
      chk("b2b_busy", {31'b0, busy}, (phase == 33) ? 32'd0 : 32'd1);
      if (phase == 33) chk("b2b_result", result, 32'hFFFFFFFE);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit beside the ALU in the execute path.
- Consumes the two register-file read operands and produces a WIDTH-bit result for the register-file write-data mux.
- Holds busy while computing so the core can freeze PC and register writes; completion is signalled by a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNTW, 6, iteration counter width; must satisfy 2**CNTW > WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  input  WIDTH  operand A (dividend / multiplicand), register-file port 1.
- rs2_data  input  WIDTH  operand B (divisor / multiplier), register-file port 2.
- busy  output  1  stall request to core.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  registered result, held until the next accepted start.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, counter=0, internal accumulators=0, result=0. done=0 and busy=0 while reset is applied. Reset mid-operation abandons the operation with no done pulse.
- States:
  - IDLE: waits for start.
  - CALC: iterating.
  - DONE: result presented.
- Transitions:
  - IDLE & start & normal op -> CALC; operands and funct3 are latched at that edge.
  - IDLE & start & special divide case -> DONE directly.
  - CALC with counter==WIDTH-1 -> DONE.
  - DONE -> IDLE unconditionally.
- busy = (state==IDLE && start) || state==CALC. busy is combinational from start so the core stalls in the request cycle. busy=0 in DONE.
- done = (state==DONE). result is registered and is valid on the same cycle done is high.
- start is ignored in CALC and DONE. Operand changes after acceptance have no effect.
- Latency: start accepted at edge T. Normal ops: done high in cycle T+WIDTH+1, i.e. 33 cycles for WIDTH=32. Special divide cases: done high in cycle T+1.
- Multiply:
  - Shift-add on operand magnitudes, one bit per cycle, 2*WIDTH-bit product.
  - Sign handling:
    - MUL, MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU: both unsigned.
  - Product negated at the end if the sign flag is set.
  - MUL returns product[WIDTH-1:0]; MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - DIV and REM take signed operands. Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
  - DIVU and REMU take unsigned operands.
- Special cases, decided at start, no CALC:
  - Divisor==0: DIV and DIVU return all-ones; REM and REMU return rs1_data.
  - Signed overflow (A==-2^(WIDTH-1), B==-1): DIV returns 0x80000000; REM returns 0.
- The most-negative operand must work in all signed ops; magnitude is computed in WIDTH+1 bits or as unsigned WIDTH bits.
- Back-to-back: the earliest next accept is the cycle after DONE. If start is held high continuously, a new op is accepted every WIDTH+2 cycles.
- result retains its last value through IDLE; a new value appears only on the done cycle.

Test Plan:
- Reset during CALC: start MUL 3*5, assert reset_n=0 at cycle 10 -> no done pulse, result=0, busy=0, next op works normally.
- MUL / MULH: rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHU 0x00000001, MULHSU 0xFFFFFFFF; each with done exactly 33 cycles after start.
- Signed divide: rs1=-7 (0xFFFFFFF9), rs2=2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1), DIVU 0x7FFFFFFC, REMU 1.
- Divide by zero: rs1=0x12345678, rs2=0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU 0x12345678; done on the cycle after start, busy high only in the start cycle.
- Overflow and min-value: rs1=0x80000000, rs2=0xFFFFFFFF -> DIV 0x80000000, REM 0 with 1-cycle latency; MUL 0x80000000*0x80000000 -> MULH 0x40000000, MUL 0.
- Handshake: start held high for 100 cycles with MULHU 0xFFFFFFFF*0xFFFFFFFF -> done pulses every 34 cycles, result 0xFFFFFFFE each time; operand changes mid-CALC do not alter result.
